multicycle_ctrl: RTL and testbench

Parametrised multi-cycle main control unit for the MIPS datapath, successor to the single-cycle opcode decoder. It sequences each instruction through FETCH, DECODE, EXEC, MEM and WB states and drives per-state datapath strobes. It adds load/store, jump and a ready/wait memory handshake with a watchdog timeout. It sits between the instruction register's opcode field and the datapath muxes, register file, PC and memory interface.

---
 rtl/multicycle_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control unit for the MIPS datapath.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB,
// drives the per-state datapath strobes, and guards every memory access
// with a wait-cycle watchdog that parks the unit in a sticky ERR state.
module multicycle_ctrl #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int TIMEOUT = 15
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic               mem_ready_i,
  output logic               IRWrite_o,
  output logic               PCWrite_o,
  output logic               Branch_o,
  output logic               BranchNe_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic               RegWrite_o,
  output logic               RegDst_o,
  output logic               MemtoReg_o,
  output logic               ALUSrcA_o,
  output logic [1:0]         ALUSrcB_o,
  output logic [1:0]         PCSrc_o,
  output logic [ALUOP_W-1:0] ALU_op_o,
  output logic [2:0]         state_o,
  output logic               err_o
);

  // Opcodes recognised by the decoder
  localparam logic [OP_W-1:0] OP_R     = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(6'b001011);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);

  // ALU operation codes, zero-extended into ALU_op_o
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_BEQ   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_BNE   = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_LUI   = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_SLTIU = ALUOP_W'(3'b111);

  // Watchdog counter sizing; TIMEOUT=0 disables the watchdog but keeps a 1-bit counter
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd7
  } state_t;

  state_t            state;
  logic [OP_W-1:0]   op_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              err_q;
  logic              timeout_hit;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_R, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
      OP_SLTIU, OP_LUI, OP_LW, OP_SW: is_legal = 1'b1;
      default:                         is_legal = 1'b0;
    endcase
  endfunction

  // Last permitted wait cycle: a further not-ready cycle means the access has timed out
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TO_LAST));

  // State sequencing, opcode capture, watchdog counting and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      // Counter only survives a not-ready cycle that stays in FETCH/MEM
      wait_cnt <= '0;
      case (state)
        S_FETCH: begin
          if (mem_ready_i) begin
            state <= S_DECODE;
          end else if (timeout_hit) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          op_q <= instr_op_i;
          if (instr_op_i == OP_J) begin
            state <= S_FETCH;
          end else if (!is_legal(instr_op_i)) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_R, OP_ADDI, OP_SLTIU, OP_LUI: state <= S_WB;
            OP_LW, OP_SW:                    state <= S_MEM;
            OP_BEQ, OP_BNE:                  state <= S_FETCH;
            default: begin
              state <= S_ERR;
              err_q <= 1'b1;
            end
          endcase
        end
        S_MEM: begin
          if (op_q != OP_LW && op_q != OP_SW) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else if (mem_ready_i) begin
            state <= (op_q == OP_LW) ? S_WB : S_FETCH;
          end else if (timeout_hit) begin
            state <= S_ERR;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          state <= S_FETCH;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          // Unused encodings fall into the error trap
          state <= S_ERR;
          err_q <= 1'b1;
        end
      endcase
    end
  end

  // Per-state datapath strobes; everything is forced low while reset is held
  always_comb begin
    IRWrite_o  = 1'b0;
    PCWrite_o  = 1'b0;
    Branch_o   = 1'b0;
    BranchNe_o = 1'b0;
    MemRead_o  = 1'b0;
    MemWrite_o = 1'b0;
    RegWrite_o = 1'b0;
    RegDst_o   = 1'b0;
    MemtoReg_o = 1'b0;
    ALUSrcA_o  = 1'b0;
    ALUSrcB_o  = 2'b00;
    PCSrc_o    = 2'b00;
    ALU_op_o   = '0;
    if (!rst_i) begin
      case (state)
        S_FETCH: begin
          // PC+4 computed while the instruction is read
          MemRead_o = 1'b1;
          ALUSrcB_o = 2'b01;
          ALU_op_o  = ALU_ADD;
          IRWrite_o = mem_ready_i;
          PCWrite_o = mem_ready_i;
        end
        S_DECODE: begin
          // Branch target speculatively computed into ALUOut
          ALUSrcB_o = 2'b11;
          ALU_op_o  = ALU_ADD;
          if (instr_op_i == OP_J) begin
            PCWrite_o = 1'b1;
            PCSrc_o   = 2'b10;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_R: begin
              ALUSrcA_o = 1'b1;
              ALU_op_o  = ALU_RTYPE;
            end
            OP_ADDI, OP_LW, OP_SW: begin
              ALUSrcA_o = 1'b1;
              ALUSrcB_o = 2'b10;
              ALU_op_o  = ALU_ADD;
            end
            OP_SLTIU: begin
              ALUSrcA_o = 1'b1;
              ALUSrcB_o = 2'b10;
              ALU_op_o  = ALU_SLTIU;
            end
            OP_LUI: begin
              ALUSrcA_o = 1'b1;
              ALUSrcB_o = 2'b10;
              ALU_op_o  = ALU_LUI;
            end
            OP_BEQ: begin
              ALUSrcA_o = 1'b1;
              ALU_op_o  = ALU_BEQ;
              Branch_o  = 1'b1;
              PCSrc_o   = 2'b01;
            end
            OP_BNE: begin
              ALUSrcA_o  = 1'b1;
              ALU_op_o   = ALU_BNE;
              BranchNe_o = 1'b1;
              PCSrc_o    = 2'b01;
            end
            default: begin
              ALUSrcA_o = 1'b0;
            end
          endcase
        end
        S_MEM: begin
          MemRead_o  = (op_q == OP_LW);
          MemWrite_o = (op_q == OP_SW);
        end
        S_WB: begin
          RegWrite_o = 1'b1;
          RegDst_o   = (op_q == OP_R);
          MemtoReg_o = (op_q == OP_LW);
        end
        default: begin
          RegWrite_o = 1'b0;
        end
      endcase
    end
  end

  assign state_o = rst_i ? 3'd0 : state;
  assign err_o   = err_q & ~rst_i;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process queues the
// expected output vector for every cycle it drives, and a monitor process
// pops and compares each entry against the DUT outputs on the falling edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       IRWrite, PCWrite, Branch, BranchNe, MemRead, MemWrite;
  logic       RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALU_op;
  logic [2:0] state;
  logic       err;

  multicycle_ctrl #(.OP_W(6), .ALUOP_W(3), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst), .instr_op_i(instr_op), .mem_ready_i(mem_ready),
    .IRWrite_o(IRWrite), .PCWrite_o(PCWrite), .Branch_o(Branch), .BranchNe_o(BranchNe),
    .MemRead_o(MemRead), .MemWrite_o(MemWrite), .RegWrite_o(RegWrite), .RegDst_o(RegDst),
    .MemtoReg_o(MemtoReg), .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .PCSrc_o(PCSrc),
    .ALU_op_o(ALU_op), .state_o(state), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [20:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    checks = 0;
  int    errors = 0;
  logic  stim_done = 1'b0;

  // Vector layout: {state[2:0], err, flags[9:0], ALUSrcB, PCSrc, ALU_op}
  // flags = {IRWrite, PCWrite, Branch, BranchNe, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA}
  function automatic logic [20:0] mk(input logic [2:0] st, input logic er, input logic [9:0] f,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic [2:0] aop);
    return {st, er, f, asb, pcs, aop};
  endfunction

  logic [20:0] Z, F_RDY, F_WAIT, D, D_J, E_R, E_ADDI, E_SLTIU, E_LUI, E_MEM;
  logic [20:0] E_BEQ, E_BNE, M_LW, M_SW, W_R, W_I, W_LW, ERRV;

  task automatic cyc(input logic r, input logic rdy, input logic [5:0] op,
                     input logic [20:0] e, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    rst       = r;
    mem_ready = rdy;
    instr_op  = op;
    it.exp    = e;
    it.name   = nm;
    sb.push_back(it);
  endtask

  // Stimulus with hand-computed expected vectors
  initial begin
    rst = 1'b1; mem_ready = 1'b0; instr_op = 6'b000000;
    Z       = mk(3'd0, 1'b0, 10'b0000000000, 2'b00, 2'b00, 3'b000);
    F_RDY   = mk(3'd0, 1'b0, 10'b1100100000, 2'b01, 2'b00, 3'b010);
    F_WAIT  = mk(3'd0, 1'b0, 10'b0000100000, 2'b01, 2'b00, 3'b010);
    D       = mk(3'd1, 1'b0, 10'b0000000000, 2'b11, 2'b00, 3'b010);
    D_J     = mk(3'd1, 1'b0, 10'b0100000000, 2'b11, 2'b10, 3'b010);
    E_R     = mk(3'd2, 1'b0, 10'b0000000001, 2'b00, 2'b00, 3'b000);
    E_ADDI  = mk(3'd2, 1'b0, 10'b0000000001, 2'b10, 2'b00, 3'b010);
    E_SLTIU = mk(3'd2, 1'b0, 10'b0000000001, 2'b10, 2'b00, 3'b111);
    E_LUI   = mk(3'd2, 1'b0, 10'b0000000001, 2'b10, 2'b00, 3'b101);
    E_MEM   = mk(3'd2, 1'b0, 10'b0000000001, 2'b10, 2'b00, 3'b010);
    E_BEQ   = mk(3'd2, 1'b0, 10'b0010000001, 2'b00, 2'b01, 3'b011);
    E_BNE   = mk(3'd2, 1'b0, 10'b0001000001, 2'b00, 2'b01, 3'b100);
    M_LW    = mk(3'd3, 1'b0, 10'b0000100000, 2'b00, 2'b00, 3'b000);
    M_SW    = mk(3'd3, 1'b0, 10'b0000010000, 2'b00, 2'b00, 3'b000);
    W_R     = mk(3'd4, 1'b0, 10'b0000001100, 2'b00, 2'b00, 3'b000);
    W_I     = mk(3'd4, 1'b0, 10'b0000001000, 2'b00, 2'b00, 3'b000);
    W_LW    = mk(3'd4, 1'b0, 10'b0000001010, 2'b00, 2'b00, 3'b000);
    ERRV    = mk(3'd7, 1'b1, 10'b0000000000, 2'b00, 2'b00, 3'b000);

    cyc(1, 1, 6'b000000, Z, "reset_hold");
    // addi, zero-wait
    cyc(0, 1, 6'b001000, F_RDY,  "addi_fetch");
    cyc(0, 1, 6'b001000, D,      "addi_decode");
    cyc(0, 1, 6'b001000, E_ADDI, "addi_exec");
    cyc(0, 1, 6'b001000, W_I,    "addi_wb");
    // lw with two wait cycles in MEM
    cyc(0, 1, 6'b100011, F_RDY,  "lw_fetch");
    cyc(0, 1, 6'b100011, D,      "lw_decode");
    cyc(0, 1, 6'b100011, E_MEM,  "lw_exec");
    cyc(0, 0, 6'b100011, M_LW,   "lw_mem_wait1");
    cyc(0, 0, 6'b100011, M_LW,   "lw_mem_wait2");
    cyc(0, 1, 6'b100011, M_LW,   "lw_mem_ready");
    cyc(0, 1, 6'b100011, W_LW,   "lw_wb");
    // bne and beq
    cyc(0, 1, 6'b000101, F_RDY,  "bne_fetch");
    cyc(0, 1, 6'b000101, D,      "bne_decode");
    cyc(0, 1, 6'b000101, E_BNE,  "bne_exec");
    cyc(0, 1, 6'b000100, F_RDY,  "beq_fetch");
    cyc(0, 1, 6'b000100, D,      "beq_decode");
    cyc(0, 1, 6'b000100, E_BEQ,  "beq_exec");
    // j
    cyc(0, 1, 6'b000010, F_RDY,  "j_fetch");
    cyc(0, 1, 6'b000010, D_J,    "j_decode");
    // R-type
    cyc(0, 1, 6'b000000, F_RDY,  "r_fetch");
    cyc(0, 1, 6'b000000, D,      "r_decode");
    cyc(0, 1, 6'b000000, E_R,    "r_exec");
    cyc(0, 1, 6'b000000, W_R,    "r_wb");
    // sltiu with one fetch wait
    cyc(0, 0, 6'b001011, F_WAIT,  "sltiu_fetch_wait");
    cyc(0, 1, 6'b001011, F_RDY,   "sltiu_fetch");
    cyc(0, 1, 6'b001011, D,       "sltiu_decode");
    cyc(0, 1, 6'b001011, E_SLTIU, "sltiu_exec");
    cyc(0, 1, 6'b001011, W_I,     "sltiu_wb");
    // lui
    cyc(0, 1, 6'b001111, F_RDY,  "lui_fetch");
    cyc(0, 1, 6'b001111, D,      "lui_decode");
    cyc(0, 1, 6'b001111, E_LUI,  "lui_exec");
    cyc(0, 1, 6'b001111, W_I,    "lui_wb");
    // sw with one MEM wait
    cyc(0, 1, 6'b101011, F_RDY,  "sw_fetch");
    cyc(0, 1, 6'b101011, D,      "sw_decode");
    cyc(0, 1, 6'b101011, E_MEM,  "sw_exec");
    cyc(0, 0, 6'b101011, M_SW,   "sw_mem_wait");
    cyc(0, 1, 6'b101011, M_SW,   "sw_mem_ready");
    // Ready on the last permitted fetch cycle is accepted
    for (int i = 0; i < 14; i++) cyc(0, 0, 6'b001000, F_WAIT, "fetch_wait_last_ok");
    cyc(0, 1, 6'b001000, F_RDY,  "fetch_ready_at_limit");
    cyc(0, 1, 6'b001000, D,      "limit_decode");
    cyc(0, 1, 6'b001000, E_ADDI, "limit_exec");
    cyc(0, 1, 6'b001000, W_I,    "limit_wb");
    // Fetch timeout: 15 not-ready cycles then ERR, ready ignored in ERR
    for (int i = 0; i < 15; i++) cyc(0, 0, 6'b001000, F_WAIT, "fetch_timeout_wait");
    cyc(0, 0, 6'b001000, ERRV,   "fetch_timeout_err");
    cyc(0, 1, 6'b001000, ERRV,   "err_hold_ready");
    cyc(1, 0, 6'b001000, Z,      "err_reset");
    // MEM timeout on lw
    cyc(0, 1, 6'b100011, F_RDY,  "lwto_fetch");
    cyc(0, 1, 6'b100011, D,      "lwto_decode");
    cyc(0, 1, 6'b100011, E_MEM,  "lwto_exec");
    for (int i = 0; i < 15; i++) cyc(0, 0, 6'b100011, M_LW, "lwto_mem_wait");
    cyc(0, 0, 6'b100011, ERRV,   "lwto_err");
    cyc(1, 0, 6'b100011, Z,      "lwto_reset");
    // Illegal opcode
    cyc(0, 1, 6'b111111, F_RDY,  "illegal_fetch");
    cyc(0, 1, 6'b111111, D,      "illegal_decode");
    cyc(0, 1, 6'b111111, ERRV,   "illegal_err");
    cyc(0, 0, 6'b111111, ERRV,   "illegal_err_hold");
    cyc(1, 0, 6'b111111, Z,      "illegal_reset");
    // Reset in the middle of a pending sw
    cyc(0, 1, 6'b101011, F_RDY,  "swrst_fetch_err_clear");
    cyc(0, 1, 6'b101011, D,      "swrst_decode");
    cyc(0, 1, 6'b101011, E_MEM,  "swrst_exec");
    cyc(0, 0, 6'b101011, M_SW,   "swrst_mem_wait");
    cyc(1, 1, 6'b101011, Z,      "swrst_reset_drops_strobe");
    cyc(0, 1, 6'b101011, F_RDY,  "swrst_fetch");
    stim_done = 1'b1;
  end

  // Monitor: pops one expected vector per cycle and compares on the falling edge
  initial begin
    item_t       it;
    logic [20:0] act;
    int          guard = 0;
    while (!(stim_done && sb.size() == 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (sb.size() > 0) begin
        it  = sb.pop_front();
        act = mk(state, err, {IRWrite, PCWrite, Branch, BranchNe, MemRead, MemWrite,
                              RegWrite, RegDst, MemtoReg, ALUSrcA}, ALUSrcB, PCSrc, ALU_op);
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL cycle_budget: got %0d cycles expected under 2000", guard);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
